branch_resolve_unit: RTL and testbench

- Back end of the branch-prediction loop.
- Records each prediction made at decode in a small in-order queue.
- When the branch resolves in MEM, compares the actual outcome with the queued prediction and raises a registered mispredict/redirect for the fetch unit.
- Emits a one-cycle counter-update strobe back to the predictor and keeps saturating branch/mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 87 ++++++++
 tb/tb_branch_resolve_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of decode-time predictions, checked against
// the MEM-stage outcome to produce a registered mispredict/redirect and predictor update.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_push_i,
  input  logic             id_pred_taken_i,
  input  logic [31:0]      id_pc_i,
  input  logic [31:0]      id_target_i,
  input  logic             mem_resolve_i,
  input  logic             mem_taken_i,
  input  logic [31:0]      mem_target_i,
  output logic             mispredict_o,
  output logic [31:0]      redirect_pc_o,
  output logic             upd_valid_o,
  output logic             upd_taken_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o,
  output logic             err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] tgt;
  } entry_t;

  entry_t        q [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_res, mis, do_push, err_set;

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign head    = q[rd_ptr];
  assign do_res  = mem_resolve_i && !empty_o;
  assign mis     = do_res && ((head.taken != mem_taken_i) ||
                              (mem_taken_i && (head.tgt != mem_target_i)));
  // A same-cycle pop frees the slot; a mispredict makes the pushed branch wrong-path.
  assign do_push = id_push_i && !mis && (!full_o || do_res);
  assign err_set = (id_push_i && full_o && !do_res) || (mem_resolve_i && empty_o);

  // Entry storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) q[wr_ptr] <= {id_pred_taken_i, id_pc_i, id_target_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      cnt              <= '0;
      mispredict_o     <= 1'b0;
      redirect_pc_o    <= '0;
      upd_valid_o      <= 1'b0;
      upd_taken_o      <= 1'b0;
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
      err_o            <= 1'b0;
    end else begin
      if (mis) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_res)  rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(do_push) - CW'(do_res);
      end
      mispredict_o <= mis;
      upd_valid_o  <= do_res;
      upd_taken_o  <= do_res && mem_taken_i;
      if (mis) redirect_pc_o <= mem_taken_i ? mem_target_i : head.pc + 32'd4;
      if (do_res && (branch_cnt_o != '1)) branch_cnt_o <= branch_cnt_o + 1'b1;
      if (mis && (mispredict_cnt_o != '1)) mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
      if (err_set) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based reference model predicts
// each cycle's status and each resolve result; a monitor compares DUT outputs.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_i, id_push_i, id_pred_taken_i, mem_resolve_i, mem_taken_i;
  logic [31:0]      id_pc_i, id_target_i, mem_target_i;
  logic             mispredict_o, upd_valid_o, upd_taken_o, full_o, empty_o, err_o;
  logic [31:0]      redirect_pc_o;
  logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_push_i(id_push_i), .id_pred_taken_i(id_pred_taken_i),
    .id_pc_i(id_pc_i), .id_target_i(id_target_i),
    .mem_resolve_i(mem_resolve_i), .mem_taken_i(mem_taken_i), .mem_target_i(mem_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o),
    .full_o(full_o), .empty_o(empty_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o), .err_o(err_o)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic             full, empty, err, mis;
    logic [31:0]      redirect;
    logic [CNT_W-1:0] bcnt, mcnt;
  } stat_t;

  typedef struct {
    logic        taken, mis;
    logic [31:0] redirect;
  } res_t;

  ent_t  mq[$];
  stat_t stat_q[$];
  res_t  res_q[$];

  logic             m_err;
  logic [CNT_W-1:0] m_bcnt, m_mcnt;
  logic [31:0]      m_redirect;
  int               n_pass = 0, n_tot = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // One clock of stimulus; the model advances to the state after the coming edge.
  task automatic cyc(input logic rst, push, pt, input logic [31:0] pc, tgt,
                     input logic res, mt, input logic [31:0] mtgt);
    ent_t  h;
    logic  m_mis, popped, was_full;
    stat_t s;
    res_t  r;
    @(posedge clk); #2;
    rst_i = rst; id_push_i = push; id_pred_taken_i = pt; id_pc_i = pc; id_target_i = tgt;
    mem_resolve_i = res; mem_taken_i = mt; mem_target_i = mtgt;
    m_mis = 1'b0; popped = 1'b0;
    if (rst) begin
      mq.delete(); m_err = 1'b0; m_bcnt = '0; m_mcnt = '0; m_redirect = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (res && mq.size() == 0) m_err = 1'b1;
      else if (res) begin
        h = mq.pop_front();
        popped = 1'b1;
        m_mis = (h.taken != mt) || (mt && h.tgt != mtgt);
        if (m_bcnt != '1) m_bcnt = m_bcnt + 1'b1;
        if (m_mis) begin
          if (m_mcnt != '1) m_mcnt = m_mcnt + 1'b1;
          m_redirect = mt ? mtgt : h.pc + 32'd4;
        end
        r.taken = mt; r.mis = m_mis; r.redirect = m_redirect;
        res_q.push_back(r);
      end
      if (push && !m_mis) begin
        if (was_full && !popped) m_err = 1'b1;
        else mq.push_back({pt, pc, tgt});
      end
      if (m_mis) mq.delete();
    end
    s.full = (mq.size() == DEPTH); s.empty = (mq.size() == 0); s.err = m_err;
    s.mis = m_mis; s.redirect = m_redirect; s.bcnt = m_bcnt; s.mcnt = m_mcnt;
    stat_q.push_back(s);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: status every cycle, resolve results whenever the DUT strobes an update.
  initial begin : monitor
    stat_t s;
    res_t  r;
    forever begin
      @(posedge clk); #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("full", full_o, s.full);
        chk("empty", empty_o, s.empty);
        chk("err", err_o, s.err);
        chk("mispredict", mispredict_o, s.mis);
        chk("redirect_pc", redirect_pc_o, s.redirect);
        chk("branch_cnt", branch_cnt_o, s.bcnt);
        chk("mispredict_cnt", mispredict_cnt_o, s.mcnt);
      end
      if (upd_valid_o === 1'b1) begin
        if (res_q.size() == 0) chk("spurious_upd_valid", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("upd_taken", upd_taken_o, r.taken);
          chk("upd_mispredict", mispredict_o, r.mis);
          if (r.mis) chk("upd_redirect", redirect_pc_o, r.redirect);
        end
      end
    end
  end

  initial begin : stim
    logic        rst, push, pt, res, mt;
    logic [31:0] pc, tgt, mtgt;
    rst_i = 1'b1; id_push_i = 0; id_pred_taken_i = 0; id_pc_i = 0; id_target_i = 0;
    mem_resolve_i = 0; mem_taken_i = 0; mem_target_i = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Correct taken prediction
    cyc(0, 1, 1, 32'h100, 32'h80, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h80);
    // Predicted not-taken, actually taken
    cyc(0, 1, 0, 32'h200, 32'h999, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h240);
    idle();
    // Not-taken fall-through wraps to zero
    cyc(0, 1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    // Target mismatch
    cyc(0, 1, 1, 32'h400, 32'h500, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h504);
    // Fill, overflow, push+pop when full, mispredict with push
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 32'h1000 + 32'(i * 16), 32'h2000, 0, 0, 0);
    cyc(0, 1, 0, 32'h3000, 32'h2000, 0, 0, 0);
    cyc(0, 1, 0, 32'h3100, 32'h2000, 1, 0, 0);
    cyc(0, 1, 0, 32'h3200, 32'h2000, 1, 1, 32'h7000);
    idle();
    // Reset clears error; then drive branch counter into saturation
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h500, 32'h600, 0, 0, 0);
    for (int i = 0; i < 34; i++) cyc(0, 1, 0, 32'h500, 32'h600, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    // Reset with three entries queued
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h800, 32'h900, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 79) == 0);
      push = ($urandom_range(0, 2) != 0);
      pt   = 1'($urandom_range(0, 1));
      pc   = $urandom & 32'hFFFF_FFFC;
      tgt  = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      res  = 1'($urandom_range(0, 1));
      if (mq.size() > 0) begin
        mt   = ($urandom_range(0, 3) == 0) ? !mq[0].taken : mq[0].taken;
        mtgt = ($urandom_range(0, 3) == 0) ? 32'h1000 + 32'(4 * $urandom_range(0, 3)) : mq[0].tgt;
      end else begin
        mt   = 1'($urandom_range(0, 1));
        mtgt = 32'h1000;
      end
      cyc(rst, push, pt, pc, tgt, res, mt, mtgt);
    end
    repeat (3) idle();
    repeat (2) @(posedge clk);
    #3;
    chk("status_queue_drained", stat_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
